// File: rtl/seq_shift_right_if.sv
// Request/response bundle for the multi-cycle right shifter.
// master: the launching controller; slave: the shifter itself.
interface seq_shift_right_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [WIDTH-1:0]   in;
   logic [SHAMT_W-1:0] shamt;
   logic               arith;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   out;

   modport master (output start, in, shamt, arith, input busy, done, out);
   modport slave  (input start, in, shamt, arith, output busy, done, out);
endinterface

// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV, upper-halfword extract).
// Captures operand and amount, shifts one bit per cycle, then publishes the
// result with a one-cycle done pulse.
// Optional macro SEQ_SHIFT_RIGHT_FAST16_EN: take 16-bit strides while the
// remaining count is at least 16 (same results, shorter latency).
module seq_shift_right #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_shift_right_if.slave  bus
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               fill_q, fill_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   out_q, out_d;

`ifdef SEQ_SHIFT_RIGHT_FAST16_EN
   // Count compared one bit wider so the stride constant always fits.
   localparam logic [SHAMT_W:0] STRIDE = (SHAMT_W+1)'(16);
   logic [WIDTH-1:0] fill_hi;
   // Mask of the top 16 bits, used to inject the fill on a stride.
   assign fill_hi = fill_q ? ~({WIDTH{1'b1}} >> 16) : '0;
`endif

   // Next-state: accept in IDLE, step or complete in SHIFT.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               sreg_d  = bus.in;
               cnt_d   = bus.shamt;
               fill_d  = bus.arith & bus.in[WIDTH-1];
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == '0) begin
               out_d   = sreg_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
`ifdef SEQ_SHIFT_RIGHT_FAST16_EN
               if ({1'b0, cnt_q} >= STRIDE) begin
                  sreg_d = (sreg_q >> 16) | fill_hi;
                  cnt_d  = SHAMT_W'({1'b0, cnt_q} - STRIDE);
               end else begin
                  sreg_d = {fill_q, sreg_q[WIDTH-1:1]};
                  cnt_d  = cnt_q - 1'b1;
               end
`else
               sreg_d = {fill_q, sreg_q[WIDTH-1:1]};
               cnt_d  = cnt_q - 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.out  = out_q;

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed bench for seq_shift_right with an expected-result queue.
module tb_seq_shift_right;
   localparam int W  = 32;
   localparam int SW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0] exp_q[$];

   seq_shift_right_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
   seq_shift_right #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(input logic [W-1:0] v, input int sh, input logic ar);
      if (ar) return W'($signed(v) >>> sh);
      return v >> sh;
   endfunction

   function automatic int lat(input int sh);
`ifdef SEQ_SHIFT_RIGHT_FAST16_EN
      return (sh >> 4) + (sh & 15) + 1;
`else
      return sh + 1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request, take the accepting edge, queue its expected result.
   task automatic accept(input logic [W-1:0] v, input int sh, input logic ar);
      bus.start = 1'b1; bus.in = v; bus.shamt = SW'(sh); bus.arith = ar;
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_q.push_back(model(v, sh, ar));
      chk("busy_after_accept", W'(bus.busy), W'(1));
   endtask

   // Wait (bounded) for done; check latency from the accepting edge, result, pulse width.
   task automatic wait_done(input string tag, input int exp_lat, input bit hold_next);
      int n = 0;
      logic [W-1:0] e;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.done && n < 200);
      e = exp_q.pop_front();
      chk({tag, "_latency"}, W'(n), W'(exp_lat));
      chk({tag, "_out"}, bus.out, e);
      if (!hold_next) begin
         @(posedge clk); #1;
         chk({tag, "_done_width"}, W'(bus.done), W'(0));
      end
   endtask

   initial begin
      int pulses;
      logic [W-1:0] held;
      bus.start = 1'b0; bus.in = '0; bus.shamt = '0; bus.arith = 1'b0;
      #2;
      chk("reset_busy", W'(bus.busy), W'(0));
      chk("reset_done", W'(bus.done), W'(0));
      chk("reset_out",  bus.out, W'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of an operation.
      accept(32'hFFFF0000, 10, 1'b0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", W'(bus.busy), W'(0));
      chk("midrst_done", W'(bus.done), W'(0));
      chk("midrst_out",  bus.out, W'(0));
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      repeat (20) begin @(posedge clk); #1; if (bus.done) pulses++; end
      chk("midrst_no_done", W'(pulses), W'(0));

      // Logical shift.
      accept(32'hF0000001, 4, 1'b0);
      wait_done("srl4", lat(4), 1'b0);
      chk("srl4_value", bus.out, 32'h0F000000);

      // Arithmetic shift by WIDTH-1.
      accept(32'h80000000, 31, 1'b1);
      wait_done("sra31", lat(31), 1'b0);
      chk("sra31_value", bus.out, 32'hFFFFFFFF);

      // Logical shift by WIDTH-1 of a negative operand.
      accept(32'h80000000, 31, 1'b0);
      wait_done("srl31", lat(31), 1'b0);

      // Upper halfword extract.
      accept(32'hABCD1234, 16, 1'b0);
      wait_done("uhw", lat(16), 1'b0);
      chk("uhw_value", bus.out, 32'h0000ABCD);

      // Arithmetic, mixed stride/bit steps.
      accept(32'h9234_5678, 20, 1'b1);
      wait_done("sra20", lat(20), 1'b0);

      // Zero shift with a start pulse while busy.
      accept(32'h12345678, 0, 1'b0);
      bus.start = 1'b1; bus.in = 32'h1; bus.shamt = 3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("zero_done", W'(bus.done), W'(1));
      chk("zero_out", bus.out, exp_q.pop_front());
      held = bus.out;
      pulses = 0;
      repeat (10) begin @(posedge clk); #1; if (bus.done) pulses++; end
      chk("busy_ignore_no_done", W'(pulses), W'(0));
      chk("busy_ignore_out", bus.out, held);

      // Back-to-back: start held high across the done cycle.
      accept(32'h000000F0, 4, 1'b0);
      bus.start = 1'b1; bus.in = 32'h00000100; bus.shamt = 8; bus.arith = 1'b0;
      wait_done("b2b_first", lat(4), 1'b1);
      chk("b2b_idle_on_done", W'(bus.busy), W'(0));
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_q.push_back(model(32'h00000100, 8, 1'b0));
      chk("b2b_second_accepted", W'(bus.busy), W'(1));
      wait_done("b2b_second", lat(8), 1'b0);
      chk("b2b_value", bus.out, 32'h00000001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_shift_right.md
Name: seq_shift_right

Overview:
- Multi-cycle right shifter for the datapath: the counterpart to the fixed left-shift used for upper-immediate loads.
- Serves the SRL, SRA, SRLV and SRAV instructions, and extracts upper halfwords.
- Accepts one operand and shift amount per request, iterates internally, and returns the result with a one-cycle done pulse.
- Sits beside the ALU and is launched by the control FSM.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two and at least 16.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only while busy=0.
- in  input  WIDTH  operand, captured on the accepting edge.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1, captured on the accepting edge.
- arith  input  1  1 = arithmetic shift (fill with the captured in[WIDTH-1]); 0 = logical shift (fill with 0).
- busy  output  1  high from the edge after acceptance until the edge that raises done.
- done  output  1  one-cycle pulse when out is updated.
- out  output  WIDTH  result register; holds its value until the next completion.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: with rst_n=0, state=IDLE, busy=0, done=0, out=0, and the internal shift register and counter are cleared. This applies immediately, including in the middle of an operation; an in-flight request is discarded and produces no done.
- State IDLE:
  - busy=0.
  - On an edge with start=1: load sreg<=in, cnt<=shamt, fill<=arith & in[WIDTH-1]; set busy<=1; go to SHIFT.
  - On an edge with start=0: no change.
- State SHIFT:
  - If cnt==0: out<=sreg, done<=1, busy<=0, go to IDLE.
  - Otherwise: sreg<={fill, sreg[WIDTH-1:1]} and cnt<=cnt-1.
- done is cleared on every edge where it was not just set, so it is exactly one cycle wide.
- Latency: shamt+1 edges from the accepting edge to the edge that raises done. With shamt=0, done is high after the first edge following acceptance.
- start while busy=1 is ignored; no queuing.
- Back-to-back requests: start may be high in the same cycle as done. The IDLE state is entered on the done edge, so a new request is accepted on the following edge. Minimum initiation interval is shamt+2 cycles.
- Inputs in, shamt and arith may change freely after acceptance; only the captured copies are used.
- Arithmetic fill is fixed at acceptance. Shifting by WIDTH-1 yields all ones for a negative operand (arith=1) and 0 or 1 for a logical shift, depending on bit WIDTH-1.
- out is never modified except on a completion edge or by reset.

Optional Feature:
- Macro: SEQ_SHIFT_RIGHT_FAST16_EN.
- When defined: in SHIFT, if cnt>=16, then sreg<={{16{fill}}, sreg[WIDTH-1:16]} and cnt<=cnt-16. Otherwise the 1-bit step applies.
  - Latency becomes (shamt>>4) + (shamt&15) + 1 edges.
  - Example: shamt=16 gives 2 edges; shamt=20 gives 6 edges.
- When undefined: only 1-bit steps; latency is exactly shamt+1.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset mid-operation: start with in=0xFFFF0000, shamt=10, arith=0. Assert rst_n=0 after 3 cycles -> busy, done and out are 0 immediately; no done pulse follows after release.
- Logical shift: in=0xF0000001, shamt=4, arith=0 -> done one cycle, 5 edges after acceptance; out=0x0F000000.
- Arithmetic shift: in=0x80000000, shamt=31, arith=1 -> out=0xFFFFFFFF. Latency is 32 edges in the default build and 17 edges with SEQ_SHIFT_RIGHT_FAST16_EN.
- Upper-halfword extract: in=0xABCD1234, shamt=16, arith=0 -> out=0x0000ABCD. Latency is 17 edges in the default build and 2 with the macro.
- Zero shift with busy-ignore: in=0x12345678, shamt=0 -> out=0x12345678 after 1 edge. A second start pulse (in=0x1, shamt=3) asserted while busy is ignored; out is unchanged and only one done pulse occurs.
- Back-to-back: hold start=1 across a done cycle with new in=0x00000100, shamt=8 -> the second request is accepted the edge after done; out=0x00000001 after a further 9 edges.
